// File: rtl/strobe_sequencer.sv
// rtl/strobe_sequencer.sv - programmable, abortable burst strobe generator
// Optional feature macro: STROBE_SEQ_IRQ_EN (adds o_irq completion pulse)
module strobe_sequencer #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk_in,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_num,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_strobe,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_strobe_count
`ifdef STROBE_SEQ_IRQ_EN
  ,
  output logic             o_irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_cfg_ready;
  logic             r_strobe;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_strobe_count;
  logic [DIV_W-1:0] r_div_reg;
  logic [CNT_W-1:0] r_num_reg;
  logic [DIV_W-1:0] r_div_cnt;
`ifdef STROBE_SEQ_IRQ_EN
  logic             r_irq;
`endif

  // Config transfer happens only while the block advertises ready (IDLE/DONE).
  logic             w_cfg_fire;
  // Divider terminal count and the strobe count it would produce.
  logic             w_div_hit;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_last_strobe;

  assign w_cfg_fire    = i_cfg_valid && r_cfg_ready;
  assign w_div_hit     = (r_div_cnt == r_div_reg);
  assign w_count_inc   = r_strobe_count + CNT_W'(1);
  assign w_last_strobe = (r_num_reg != '0) && (w_count_inc == r_num_reg);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cfg_ready    <= 1'b1;
      r_strobe       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_strobe_count <= '0;
      r_div_reg      <= '0;
      r_num_reg      <= '0;
      r_div_cnt      <= '0;
`ifdef STROBE_SEQ_IRQ_EN
      r_irq          <= 1'b0;
`endif
    end else begin
`ifdef STROBE_SEQ_IRQ_EN
      r_irq <= 1'b0;
`endif
      case (r_state)
        S_IDLE, S_DONE: begin
          // A config accepted on the start edge is the one the burst uses,
          // because the divider reads r_div_reg only from the next edge on.
          if (w_cfg_fire) begin
            r_div_reg <= i_cfg_div;
            r_num_reg <= i_cfg_num;
          end
          r_strobe <= 1'b0;
          if (i_start) begin
            r_state        <= S_RUN;
            r_div_cnt      <= '0;
            r_strobe_count <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b1;
            r_cfg_ready    <= 1'b0;
          end else if (w_cfg_fire) begin
            // New config while finished drops the done indication.
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else if (r_state == S_DONE) begin
            // First DONE cycle follows the last strobe: settle the status.
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cfg_ready <= 1'b1;
`ifdef STROBE_SEQ_IRQ_EN
            r_irq       <= !r_done;
`endif
          end
        end

        S_RUN: begin
          if (i_abort) begin
            // Abort beats a pending strobe; the count shows strobes issued.
            r_state     <= S_IDLE;
            r_strobe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else if (w_div_hit) begin
            r_strobe       <= 1'b1;
            r_div_cnt      <= '0;
            r_strobe_count <= w_count_inc;
            if (w_last_strobe) begin
              r_state <= S_DONE;
            end
          end else begin
            r_strobe  <= 1'b0;
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_strobe    <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_cfg_ready    = r_cfg_ready;
  assign o_strobe       = r_strobe;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_strobe_count = r_strobe_count;
`ifdef STROBE_SEQ_IRQ_EN
  assign o_irq          = r_irq;
`endif

endmodule

// File: tb/tb_strobe_sequencer.sv
// tb/tb_strobe_sequencer.sv - directed self-checking bench for strobe_sequencer
module tb_strobe_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_num;
  logic       start;
  logic       abort;
  logic       strobe;
  logic       busy;
  logic       done;
  logic [7:0] strobe_count;
`ifdef STROBE_SEQ_IRQ_EN
  logic       irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_irq = 0;

  always #5 clk = ~clk;

  strobe_sequencer #(.DIV_W(8), .CNT_W(8)) dut (
    .i_clk_in      (clk),
    .i_rst         (rst),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_div     (cfg_div),
    .i_cfg_num     (cfg_num),
    .i_start       (start),
    .i_abort       (abort),
    .o_strobe      (strobe),
    .o_busy        (busy),
    .o_done        (done),
    .o_strobe_count(strobe_count)
`ifdef STROBE_SEQ_IRQ_EN
    ,
    .o_irq         (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then read 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
`ifdef STROBE_SEQ_IRQ_EN
    if (irq === 1'b1) n_irq++;
`endif
  endtask

  task automatic do_cfg(input logic [7:0] d, input logic [7:0] n);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_num   = n;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_status(input string tag, input logic [7:0] cnt, input logic exp_done);
    chk({tag, "_strobe"}, 32'(strobe), 32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_done"},   32'(done),   32'(exp_done));
    chk({tag, "_count"},  32'(strobe_count), 32'(cnt));
    chk({tag, "_ready"},  32'(cfg_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_num = '0;
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_idle_status("reset", 8'd0, 1'b0);

    // Basic burst: period 4, five strobes, first 4 edges after start.
    do_cfg(8'd3, 8'd5);
    do_start();
    chk("basic_busy_at_start", 32'(busy), 32'd1);
    chk("basic_ready_in_run", 32'(cfg_ready), 32'd0);
    n_irq = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk($sformatf("basic_strobe_c%0d", i), 32'(strobe),
          32'(((i % 4) == 0) && (i <= 20)));
      if (i == 20) chk("basic_count_last", 32'(strobe_count), 32'd5);
      if (i == 20) chk("basic_busy_last", 32'(busy), 32'd1);
    end
    check_idle_status("basic_end", 8'd5, 1'b1);
`ifdef STROBE_SEQ_IRQ_EN
    chk("basic_irq_pulses", 32'(n_irq), 32'd1);
`endif

    // Config in DONE returns to IDLE; then every-cycle burst of 3.
    do_cfg(8'd0, 8'd3);
    chk("cfg_in_done_clears_done", 32'(done), 32'd0);
    do_start();
    n_irq = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("every_strobe_c%0d", i), 32'(strobe), 32'(i <= 3));
    end
    check_idle_status("every_end", 8'd3, 1'b1);
`ifdef STROBE_SEQ_IRQ_EN
    chk("every_irq_pulses", 32'(n_irq), 32'd1);
`endif

    // Continuous mode: count wraps 255 -> 0 and never completes.
    do_cfg(8'd0, 8'd0);
    do_start();
    n_irq = 0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (i == 255) chk("cont_count_255", 32'(strobe_count), 32'd255);
      if (i == 256) chk("cont_count_wrap", 32'(strobe_count), 32'd0);
      if (i == 256) chk("cont_busy_wrap", 32'(busy), 32'd1);
    end
    chk("cont_count_260", 32'(strobe_count), 32'd4);
    chk("cont_done", 32'(done), 32'd0);
    chk("cont_busy", 32'(busy), 32'd1);
    chk("cont_strobe", 32'(strobe), 32'd1);
    // Abort on an edge that would otherwise strobe: count stays at 4.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_status("cont_abort", 8'd4, 1'b0);
`ifdef STROBE_SEQ_IRQ_EN
    chk("cont_irq_pulses", 32'(n_irq), 32'd0);
`endif

    // Abort after the 3rd strobe of a period-2 burst of 10.
    do_cfg(8'd1, 8'd10);
    do_start();
    n_irq = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("abort_strobe_c%0d", i), 32'(strobe), 32'((i % 2) == 0));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_status("abort_end", 8'd3, 1'b0);
    tick(); tick();
    chk("abort_still_idle_strobe", 32'(strobe), 32'd0);
`ifdef STROBE_SEQ_IRQ_EN
    chk("abort_irq_pulses", 32'(n_irq), 32'd0);
`endif

    // Collision: config held off during RUN, start during RUN ignored.
    do_cfg(8'd5, 8'd2);
    do_start();
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_num = 8'd1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      if (i == 11) cfg_valid = 1'b0;
      if (i == 3) chk("coll_ready_run", 32'(cfg_ready), 32'd0);
      chk($sformatf("coll_strobe_c%0d", i), 32'(strobe), 32'((i == 6) || (i == 12)));
      if (i == 6) chk("coll_count_first", 32'(strobe_count), 32'd1);
    end
    check_idle_status("coll_done", 8'd2, 1'b1);
    // In DONE: new config with start on the same edge -> period 3.
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_num = 8'd2; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("coll_restart_busy", 32'(busy), 32'd1);
    chk("coll_restart_done", 32'(done), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("coll_new_strobe_c%0d", i), 32'(strobe), 32'((i == 3) || (i == 6)));
    end
    check_idle_status("coll_new_end", 8'd2, 1'b1);

    // Reset mid-RUN with period 5; latched config is lost afterwards.
    do_cfg(8'd4, 8'd0);
    do_start();
    for (int i = 1; i <= 7; i++) tick();
    chk("rst_pre_count", 32'(strobe_count), 32'd1);
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check_idle_status("rst_mid", 8'd0, 1'b0);
    do_start();
    tick();
    chk("rst_cfg_lost_strobe", 32'(strobe), 32'd1);
    chk("rst_cfg_lost_count", 32'(strobe_count), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rst_final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/strobe_sequencer.md
Name: strobe_sequencer

Overview:
Controller that sequences a single-clock strobe generator. It accepts a divide ratio and a pulse count through a valid/ready config handshake. On start it emits one-cycle enable strobes every (cfg_div+1) clocks until the programmed number of strobes is reached. It sits between the control logic and the strobe-driven counter datapath, replacing free-running dividers with a programmable, abortable burst.

Parameters:
DIV_W, 8, width of divide-ratio field and internal divider counter
CNT_W, 8, width of pulse-count field and strobe_count output

Ports:
clk_in  input  1  single system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  config word valid
cfg_ready  output  1  block can accept config (IDLE or DONE only)
cfg_div  input  DIV_W  strobe period minus one
cfg_num  input  CNT_W  strobes per burst; 0 = continuous
start  input  1  begin burst with latched config
abort  input  1  terminate running burst
strobe  output  1  one-cycle enable pulse, registered
busy  output  1  high in RUN
done  output  1  high in DONE (level)
strobe_count  output  CNT_W  strobes issued in current or last burst

Behaviour:
- Clock and reset: one clock clk_in; rst synchronous, active-high, highest priority.
- Reset values: state=IDLE, cfg_ready=1, strobe=0, busy=0, done=0, strobe_count=0, div_reg=0, num_reg=0, div_cnt=0.
- States: IDLE, RUN, DONE. All outputs are registered and decoded from state or set at the edge.
- Config handshake: transfer on cfg_valid && cfg_ready. Latches div_reg=cfg_div and num_reg=cfg_num. cfg_ready=1 in IDLE and DONE, 0 in RUN. Config offered during RUN is held off (not lost) and is not applied.
- IDLE/DONE to RUN: taken when start is sampled high. At that edge div_cnt=0, strobe_count=0, done=0, busy=1.
  - If a config handshake occurs on the same edge as start, the new cfg_div/cfg_num are used for the burst.
- RUN, each edge:
  - If div_cnt==div_reg: strobe<=1, div_cnt<=0, strobe_count<=strobe_count+1.
  - Else: strobe<=0, div_cnt<=div_cnt+1.
  - Result: first strobe is high in the cycle following edge (start edge + div_reg + 1), then repeats every div_reg+1 cycles.
  - div_reg=0 gives a strobe every cycle. div_reg=2^DIV_W-1 gives period 2^DIV_W.
- Completion: when num_reg!=0 and the incremented strobe_count equals num_reg, state goes to DONE on the same edge the last strobe is raised. On the following edge strobe<=0, busy=0, done=1.
  - done holds until the next start, or until a config handshake returns the block to IDLE.
- Continuous mode (num_reg=0): never completes. strobe_count wraps 2^CNT_W-1 -> 0 and keeps running.
- abort in RUN: next edge state=IDLE, strobe=0, busy=0, done=0, strobe_count held (shows strobes issued). abort wins over a completion or strobe on the same edge.
- abort outside RUN: ignored. start and abort both high in IDLE: start taken.
- start in RUN: ignored.
- rst mid-burst: all registers return to reset values at that edge; the latched config is lost.

Optional Feature:
STROBE_SEQ_IRQ_EN
- Defined: adds output port irq (1 bit, reset 0). irq is a one-cycle pulse in the first cycle done rises (RUN->DONE). It is not pulsed on abort or in continuous mode.
- Undefined: no irq port and no related logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles mid-RUN with div=4 -> next cycle strobe=0, busy=0, done=0, strobe_count=0, cfg_ready=1.
- Basic burst: cfg_div=3, cfg_num=5, start -> 5 strobes spaced exactly 4 cycles apart, first 4 cycles after start edge. Then busy falls, done=1, strobe_count=5. irq pulses once if enabled.
- Every-cycle: cfg_div=0, cfg_num=3 -> strobe high 3 consecutive cycles, then done=1, strobe_count=3.
- Continuous wrap: cfg_div=0, cfg_num=0, run 260 cycles -> strobe_count wraps 255->0, done stays 0, busy stays 1.
- Abort: cfg_div=1, cfg_num=10, assert abort after 3rd strobe -> next cycle IDLE, strobe=0, done=0, strobe_count=3, no irq.
- Handshake/collision: cfg_valid during RUN -> cfg_ready=0, no transfer. In DONE, cfg_div=2 with start on the same edge -> new burst uses period 3. start during RUN -> no restart, strobe_count unaffected.
